// File: rtl/cam_pkg.sv
// Shared definitions for the camera ball-locator path.
// Holds the RGB565 field positions, datapath widths and the locator FSM
// state encoding. It has no ports.
package cam_pkg;

   // RGB565 field positions
   localparam int unsigned R_HI = 15;
   localparam int unsigned R_LO = 11;
   localparam int unsigned G_HI = 10;
   localparam int unsigned G_LO = 5;
   localparam int unsigned B_HI = 4;
   localparam int unsigned B_LO = 0;

   // Datapath widths
   localparam int unsigned X_W  = 10;
   localparam int unsigned Y_W  = 8;
   localparam int unsigned N_W  = 20;
   localparam int unsigned SX_W = 30;
   localparam int unsigned SY_W = 28;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StDivX,
      StDivY,
      StReport
   } loc_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start_i       load operands and begin; also restarts a division in progress
//   dividend_i    30-bit dividend
//   divisor_i     20-bit divisor (never 0 in this design)
//   done_o        one-cycle pulse after the last of the 30 iterations
//   quotient_o    quotient, stable while done_o is high and until the next start
module seq_divider
   import cam_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [SX_W-1:0] dividend_i,
   input  logic [N_W-1:0]  divisor_i,
   output logic            done_o,
   output logic [SX_W-1:0] quotient_o
);

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [N_W:0]    rem_q, rem_d;
   logic [SX_W-1:0] quo_q, quo_d;
   logic [N_W-1:0]  dvs_q, dvs_d;

   logic [N_W:0]    rem_shift;
   logic            sub_ok;

   always_comb begin
      // The quotient register doubles as the dividend shift register.
      rem_shift = {rem_q[N_W-1:0], quo_q[SX_W-1]};
      sub_ok    = (rem_shift >= {1'b0, dvs_q});
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
      end else if (busy_q) begin
         rem_d = sub_ok ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
         quo_d = {quo_q[SX_W-2:0], sub_ok};
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'(SX_W - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/ball_locator.sv
// Ball locator: classifies RGB565 pixels against colour thresholds, accumulates
// hit statistics over a frame and reports the centroid at each frame boundary.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   pix_write      pixel strobe; pix_data / pix_x valid
//   pix_data       RGB565 pixel
//   pix_x          1-based horizontal index of the pixel
//   line_active    capture window of the current line; falling edge ends a line
//   frame_start    one-cycle vsync pulse
//   result_valid   one-cycle pulse when the result outputs update
//   ball_found     last frame had at least MIN_HITS hits
//   ball_x/ball_y  centroid (truncated quotients), 0 when not found
//   hit_count      hits in the last completed frame
//   overrun        sticky: frame_start arrived while a result was still in flight
module ball_locator
   import cam_pkg::*;
#(
   parameter logic [4:0]     R_MIN    = 5'd20,
   parameter logic [5:0]     G_MAX    = 6'd24,
   parameter logic [4:0]     B_MAX    = 5'd10,
   parameter logic [N_W-1:0] MIN_HITS = 20'd16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pix_write,
   input  logic [15:0]     pix_data,
   input  logic [X_W-1:0]  pix_x,
   input  logic            line_active,
   input  logic            frame_start,
   output logic            result_valid,
   output logic            ball_found,
   output logic [X_W-1:0]  ball_x,
   output logic [Y_W-1:0]  ball_y,
   output logic [N_W-1:0]  hit_count,
   output logic            overrun
);

   loc_state_e state_q, state_d;

   logic            line_active_q;
   logic [Y_W-1:0]  line_idx_q, line_idx_d;
   logic [N_W-1:0]  acc_n_q, acc_n_d, snap_n_q;
   logic [SX_W-1:0] acc_x_q, acc_x_d, snap_x_q;
   logic [SY_W-1:0] acc_y_q, acc_y_d, snap_y_q;

   logic            res_found_q, res_found_d;
   logic [X_W-1:0]  res_x_q, res_x_d;
   logic [Y_W-1:0]  res_y_q, res_y_d;

   logic            rv_q, rv_d;
   logic            found_q, found_d;
   logic [X_W-1:0]  bx_q, bx_d;
   logic [Y_W-1:0]  by_q, by_d;
   logic [N_W-1:0]  hc_q, hc_d;
   logic            ovr_q, ovr_d;

   logic            hit, line_fall, snap_load;
   logic            div_start, div_done;
   logic [SX_W-1:0] div_dividend, div_q;
   logic            unused_div_hi;

   assign hit = pix_write & (pix_data[R_HI:R_LO] >= R_MIN) &
                (pix_data[G_HI:G_LO] <= G_MAX) & (pix_data[B_HI:B_LO] <= B_MAX);
   assign line_fall = line_active_q & ~line_active;
   // A frame_start during an in-flight result keeps the old snapshot.
   assign snap_load = frame_start & (state_q == StIdle);
   assign unused_div_hi = ^div_q[SX_W-1:X_W];

   // Accumulators: a hit coincident with frame_start lands in the new frame.
   always_comb begin
      acc_n_d    = frame_start ? '0 : acc_n_q;
      acc_x_d    = frame_start ? '0 : acc_x_q;
      acc_y_d    = frame_start ? '0 : acc_y_q;
      line_idx_d = line_idx_q;
      if (frame_start) begin
         line_idx_d = '0;
      end else if (line_fall && (line_idx_q != '1)) begin
         line_idx_d = line_idx_q + 8'd1;
      end
      if (hit) begin
         if (acc_n_d != '1) acc_n_d = acc_n_d + 20'd1;
         acc_x_d = acc_x_d + SX_W'(pix_x);
         acc_y_d = acc_y_d + SY_W'(line_idx_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      div_start    = 1'b0;
      div_dividend = snap_x_q;
      res_found_d  = res_found_q;
      res_x_d      = res_x_q;
      res_y_d      = res_y_q;
      rv_d         = 1'b0;
      found_d      = found_q;
      bx_d         = bx_q;
      by_d         = by_q;
      hc_d         = hc_q;
      ovr_d        = ovr_q | (frame_start & (state_q != StIdle));
      unique case (state_q)
         StIdle: begin
            if (frame_start) state_d = StCheck;
         end
         StCheck: begin
            if (snap_n_q < MIN_HITS) begin
               res_found_d = 1'b0;
               res_x_d     = '0;
               res_y_d     = '0;
               state_d     = StReport;
            end else begin
               res_found_d = 1'b1;
               div_start   = 1'b1;
               state_d     = StDivX;
            end
         end
         StDivX: begin
            if (div_done) begin
               res_x_d      = div_q[X_W-1:0];
               div_start    = 1'b1;
               div_dividend = SX_W'(snap_y_q);
               state_d      = StDivY;
            end
         end
         StDivY: begin
            if (div_done) begin
               res_y_d = div_q[Y_W-1:0];
               state_d = StReport;
            end
         end
         StReport: begin
            rv_d    = 1'b1;
            found_d = res_found_q;
            bx_d    = res_x_q;
            by_d    = res_y_q;
            hc_d    = snap_n_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         line_active_q <= 1'b0;
         line_idx_q    <= '0;
         acc_n_q       <= '0;
         acc_x_q       <= '0;
         acc_y_q       <= '0;
         snap_n_q      <= '0;
         snap_x_q      <= '0;
         snap_y_q      <= '0;
         res_found_q   <= 1'b0;
         res_x_q       <= '0;
         res_y_q       <= '0;
         rv_q          <= 1'b0;
         found_q       <= 1'b0;
         bx_q          <= '0;
         by_q          <= '0;
         hc_q          <= '0;
         ovr_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_active_q <= line_active;
         line_idx_q    <= line_idx_d;
         acc_n_q       <= acc_n_d;
         acc_x_q       <= acc_x_d;
         acc_y_q       <= acc_y_d;
         if (snap_load) begin
            snap_n_q <= acc_n_q;
            snap_x_q <= acc_x_q;
            snap_y_q <= acc_y_q;
         end
         res_found_q   <= res_found_d;
         res_x_q       <= res_x_d;
         res_y_q       <= res_y_d;
         rv_q          <= rv_d;
         found_q       <= found_d;
         bx_q          <= bx_d;
         by_q          <= by_d;
         hc_q          <= hc_d;
         ovr_q         <= ovr_d;
      end
   end

   seq_divider u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (div_dividend),
      .divisor_i  (snap_n_q),
      .done_o     (div_done),
      .quotient_o (div_q)
   );

   assign result_valid = rv_q;
   assign ball_found   = found_q;
   assign ball_x       = bx_q;
   assign ball_y       = by_q;
   assign hit_count    = hc_q;
   assign overrun      = ovr_q;

endmodule
